pmem_write_buffer: RTL and testbench

- Eviction write buffer between the data cache's physical-memory port and the memory arbiter.
- Absorbs dirty-line write-backs so the data cache's line fill reaches physical memory first; buffered lines drain to memory when the downstream port is otherwise idle.
- Read requests are checked against buffered lines so the data cache never fetches stale data from memory.

---
 rtl/pmem_write_buffer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pmem_write_buffer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_write_buffer.sv
// pmem_write_buffer
//
// Eviction write buffer between the data cache's physical-memory port and the
// memory arbiter. Dirty-line write-backs are parked in a small FIFO of line
// entries so the cache's line fill reaches memory first. Buffered lines drain
// to memory whenever the data cache is not asking for anything. Reads are
// matched against the buffer so the cache never sees stale memory data.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   dc_address      data cache request address (byte address)
//   dc_read         data cache line read request (level, held until dc_resp)
//   dc_write        data cache line write request (level, held until dc_resp)
//   dc_wdata        data cache write line
//   dc_rdata        read line returned to the data cache (valid with dc_resp)
//   dc_resp         single-cycle completion pulse to the data cache
//   mem_address     address to the arbiter
//   mem_read        read request to the arbiter
//   mem_write       write request to the arbiter
//   mem_wdata       write line to the arbiter
//   mem_rdata       read line from the arbiter
//   mem_resp        arbiter completion pulse
//   full, empty     buffer occupancy flags
//
// Every output comes straight from a flop.

module pmem_write_buffer #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] dc_address,
    input  logic                  dc_read,
    input  logic                  dc_write,
    input  logic [LINE_WIDTH-1:0] dc_wdata,
    output logic [LINE_WIDTH-1:0] dc_rdata,
    output logic                  dc_resp,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned TagW = ADDR_WIDTH - OFFSET_BITS;
    // Keep pointers at least one bit wide so DEPTH=1 still elaborates.
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StResp,
        StRdMem,
        StWrMem
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [TagW-1:0]       tag_q   [DEPTH];
    logic [TagW-1:0]       tag_d   [DEPTH];
    logic [LINE_WIDTH-1:0] data_q  [DEPTH];
    logic [LINE_WIDTH-1:0] data_d  [DEPTH];
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;

    logic [LINE_WIDTH-1:0] dc_rdata_q, dc_rdata_d;
    logic                  dc_resp_q, dc_resp_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;

    // ------------------------------------------------------------------
    // Line match against buffered entries
    // ------------------------------------------------------------------
    logic [TagW-1:0] dc_tag;
    logic            hit;
    logic [PtrW-1:0] hit_idx;

    assign dc_tag = dc_address[ADDR_WIDTH-1:OFFSET_BITS];

    // Coalescing keeps tags unique, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit && valid_q[i] && (tag_q[i] == dc_tag)) begin
                hit     = 1'b1;
                hit_idx = PtrW'(i);
            end
        end
    end

    // Drains go to the line-aligned address of the head entry.
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [PtrW-1:0]       head_inc;
    logic [PtrW-1:0]       tail_inc;

    assign head_addr = ADDR_WIDTH'(tag_q[head_q]) << OFFSET_BITS;
    assign head_inc  = (head_q == PtrW'(DEPTH - 1)) ? '0 : head_q + PtrW'(1);
    assign tail_inc  = (tail_q == PtrW'(DEPTH - 1)) ? '0 : tail_q + PtrW'(1);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        data_d        = data_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        dc_rdata_d    = dc_rdata_q;
        dc_resp_d     = 1'b0;
        mem_address_d = mem_address_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_wdata_d   = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (dc_write) begin
                    if (hit) begin
                        // Coalesce in place; the entry keeps its FIFO slot.
                        data_d[hit_idx] = dc_wdata;
                        dc_resp_d       = 1'b1;
                        state_d         = StResp;
                    end else if (!full_q) begin
                        valid_d[tail_q] = 1'b1;
                        tag_d[tail_q]   = dc_tag;
                        data_d[tail_q]  = dc_wdata;
                        tail_d          = tail_inc;
                        count_d         = count_q + CntW'(1);
                        dc_resp_d       = 1'b1;
                        state_d         = StResp;
                    end else begin
                        // No room: free the head first. The write stays
                        // pending and is taken on the return to idle.
                        mem_address_d = head_addr;
                        mem_wdata_d   = data_q[head_q];
                        mem_write_d   = 1'b1;
                        state_d       = StWrMem;
                    end
                end else if (dc_read) begin
                    if (hit) begin
                        dc_rdata_d = data_q[hit_idx];
                        dc_resp_d  = 1'b1;
                        state_d    = StResp;
                    end else begin
                        mem_address_d = dc_address;
                        mem_read_d    = 1'b1;
                        state_d       = StRdMem;
                    end
                end else if (!empty_q) begin
                    mem_address_d = head_addr;
                    mem_wdata_d   = data_q[head_q];
                    mem_write_d   = 1'b1;
                    state_d       = StWrMem;
                end
            end

            // Requests are ignored here; the requester drops them at this edge.
            StResp: begin
                state_d = StIdle;
            end

            StRdMem: begin
                if (mem_resp) begin
                    mem_read_d = 1'b0;
                    dc_rdata_d = mem_rdata;
                    dc_resp_d  = 1'b1;
                    state_d    = StResp;
                end
            end

            // A drain always runs to completion; the head stays matchable
            // until this pop.
            StWrMem: begin
                if (mem_resp) begin
                    mem_write_d     = 1'b0;
                    valid_d[head_q] = 1'b0;
                    head_d          = head_inc;
                    count_d         = count_q - CntW'(1);
                    state_d         = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        full_d  = (count_d == CntW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            valid_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            dc_rdata_q    <= '0;
            dc_resp_q     <= 1'b0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            dc_rdata_q    <= dc_rdata_d;
            dc_resp_q     <= dc_resp_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_wdata_q   <= mem_wdata_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
        end
    end

    // Entry payload needs no reset: it is only ever read behind valid_q.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign dc_rdata    = dc_rdata_q;
    assign dc_resp     = dc_resp_q;
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wdata   = mem_wdata_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule

// File: tb/tb_pmem_write_buffer.sv
`timescale 1ns/1ps

module tb_pmem_write_buffer;

    localparam int DEPTH   = 2;
    localparam int AW      = 16;
    localparam int LW      = 128;
    localparam int OB      = 4;
    localparam int MEM_LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] dc_address = '0;
    logic          dc_read    = 1'b0;
    logic          dc_write   = 1'b0;
    logic [LW-1:0] dc_wdata   = '0;
    logic [LW-1:0] dc_rdata;
    logic          dc_resp;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata  = '0;
    logic          mem_resp   = 1'b0;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    pmem_write_buffer #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .OFFSET_BITS(OB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dc_address (dc_address),
        .dc_read    (dc_read),
        .dc_write   (dc_write),
        .dc_wdata   (dc_wdata),
        .dc_rdata   (dc_rdata),
        .dc_resp    (dc_resp),
        .mem_address(mem_address),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .full       (full),
        .empty      (empty)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Model state ----------------
    typedef struct {
        logic [AW-OB-1:0] tag;
        logic [LW-1:0]    data;
    } ent_t;

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } log_t;

    ent_t mq[$];     // buffered lines, oldest first
    log_t log_q[$];  // downstream requests in issue order

    int            cur_op    = 0;  // 0 none, 1 read, 2 write
    logic [AW-1:0] cur_addr  = '0;
    logic [LW-1:0] cur_wdata = '0;
    int            txn_id    = 0;
    bit            auto_resp = 1'b1;
    int            fire_req  = 0;

    function automatic logic [LW-1:0] mem_val(input logic [AW-1:0] a);
        return {8{a ^ 16'h5A5A}};
    endfunction

    function automatic int find_tag(input logic [AW-1:0] a);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == a[AW-1:OB]) return i;
        end
        return -1;
    endfunction

    // ---------------- Memory responder ----------------
    initial begin : responder
        int wcnt;
        int fire_ack;
        wcnt     = 0;
        fire_ack = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_resp = 1'b0;
                wcnt     = 0;
            end else if (mem_resp) begin
                mem_resp = 1'b0;
            end else if (fire_req != fire_ack) begin
                fire_ack  = fire_req;
                mem_resp  = 1'b1;
                mem_rdata = mem_val(mem_address);
            end else if (auto_resp && (mem_read || mem_write)) begin
                wcnt++;
                if (wcnt >= MEM_LAT) begin
                    wcnt      = 0;
                    mem_resp  = 1'b1;
                    mem_rdata = mem_val(mem_address);
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- Cycle checker ----------------
    initial begin : blk_check
        bit   pend_pop, exp_resp, prev_resp, prev_mw, prev_mr, saw_rd;
        int   seen_id;
        int   idx;
        ent_t e;
        log_t l;
        pend_pop = 0; exp_resp = 0; prev_resp = 0; prev_mw = 0; prev_mr = 0; saw_rd = 0;
        seen_id  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                pend_pop = 0; exp_resp = 0; prev_resp = 0; prev_mw = 0; prev_mr = 0;
                chk("rst_dc_resp", dc_resp, 0);
                chk("rst_mem_read", mem_read, 0);
                chk("rst_mem_write", mem_write, 0);
                chk("rst_mem_address", mem_address, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_dc_rdata", dc_rdata, 0);
                chk("rst_empty", empty, 1);
                chk("rst_full", full, 0);
            end else begin
                if (pend_pop) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    pend_pop = 0;
                end
                if (txn_id != seen_id) begin
                    seen_id = txn_id;
                    saw_rd  = 0;
                end
                chk("rw_exclusive", mem_read && mem_write, 0);
                if (exp_resp) begin
                    chk("miss_resp_latency", dc_resp, 1);
                    exp_resp = 0;
                end
                if (prev_resp) chk("resp_single_cycle", dc_resp, 0);
                if (dc_resp) begin
                    idx = find_tag(cur_addr);
                    if (cur_op == 0) begin
                        chk("spurious_resp", dc_resp, 0);
                    end else if (cur_op == 2) begin
                        if (idx >= 0) begin
                            mq[idx].data = cur_wdata;
                        end else begin
                            chk("push_room", mq.size() < DEPTH, 1);
                            e.tag  = cur_addr[AW-1:OB];
                            e.data = cur_wdata;
                            mq.push_back(e);
                        end
                    end else if (idx >= 0) begin
                        chk("hit_rdata", dc_rdata, mq[idx].data);
                        chk("hit_no_mem_read", saw_rd, 0);
                    end else begin
                        chk("miss_rdata", dc_rdata, mem_val(cur_addr));
                        chk("miss_used_mem", saw_rd, 1);
                    end
                end
                chk("full", full, mq.size() == DEPTH);
                chk("empty", empty, mq.size() == 0);
                if (mem_write) begin
                    if (mq.size() == 0) begin
                        chk("drain_from_empty", mem_write, 0);
                    end else begin
                        chk("drain_addr", mem_address, AW'(mq[0].tag) << OB);
                        chk("drain_data", mem_wdata, mq[0].data);
                    end
                    if (!prev_mw) begin
                        l.w = 1; l.a = mem_address; l.d = mem_wdata;
                        log_q.push_back(l);
                    end
                    if (mem_resp) pend_pop = 1;
                end
                if (mem_read) begin
                    saw_rd = 1;
                    chk("rd_addr", mem_address, cur_addr);
                    chk("rd_for_read", cur_op, 1);
                    chk("rd_is_miss", find_tag(cur_addr) >= 0, 0);
                    if (!prev_mr) begin
                        l.w = 0; l.a = mem_address; l.d = '0;
                        log_q.push_back(l);
                    end
                    if (mem_resp) exp_resp = 1;
                end
                prev_mw   = mem_write;
                prev_mr   = mem_read;
                prev_resp = dc_resp;
            end
        end
    end

    // ---------------- Driver helpers ----------------
    // Called at posedge+1; returns at posedge+1 of the edge leaving RESP.
    task automatic do_req(input string name, input int op, input logic [AW-1:0] a,
                          input logic [LW-1:0] d, input int exp_lat,
                          output logic [LW-1:0] rd);
        int n;
        bit got;
        cur_addr   = a;
        cur_wdata  = d;
        txn_id++;
        cur_op     = op;
        dc_address = a;
        dc_wdata   = d;
        dc_read    = (op == 1);
        dc_write   = (op == 2);
        got = 0;
        n   = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (dc_resp) got = 1;
        end
        rd = dc_rdata;
        chk({name, "_resp"}, got, 1);
        if (exp_lat > 0) chk({name, "_latency"}, n, exp_lat);
        @(posedge clk);
        #1;
        dc_read  = 1'b0;
        dc_write = 1'b0;
        cur_op   = 0;
    endtask

    task automatic wait_drained(input string name);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            ok = empty && !mem_write && !mem_read;
        end
        chk({name, "_drained"}, ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int i, input bit w,
                           input logic [AW-1:0] a, input logic [LW-1:0] d);
        if (i < log_q.size()) begin
            chk({name, "_kind"}, log_q[i].w, w);
            chk({name, "_addr"}, log_q[i].a, a);
            if (w) chk({name, "_data"}, log_q[i].d, d);
        end else begin
            chk({name, "_present"}, log_q.size(), i + 1);
        end
    endtask

    // ---------------- Directed sequence ----------------
    localparam logic [LW-1:0] DA = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [LW-1:0] DB = 128'hdead_beef_0000_1111_2222_3333_cafe_f00d;
    localparam logic [LW-1:0] DC = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [LW-1:0] DD = 128'haaaa_0001_aaaa_0002_aaaa_0003_aaaa_0004;
    localparam logic [LW-1:0] DE = 128'hbbbb_0001_bbbb_0002_bbbb_0003_bbbb_0004;
    localparam logic [LW-1:0] DF = 128'hcccc_0001_cccc_0002_cccc_0003_cccc_0004;

    initial begin
        logic [LW-1:0] rd;
        int  base;
        bit  got;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("init_empty", empty, 1);
        chk("init_full", full, 0);
        chk("init_mem_read", mem_read, 0);
        chk("init_dc_resp", dc_resp, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: write then read hit, no downstream read
        base = log_q.size();
        do_req("t1_wr", 2, 16'h1230, DA, 2, rd);
        chk("t1_not_empty", empty, 0);
        do_req("t1_rd", 1, 16'h1236, '0, 2, rd);
        chk("t1_rdata", rd, DA);
        chk("t1_no_mem_access", log_q.size(), base);
        wait_drained("t1");
        chk_log("t1_drain", base, 1, 16'h1230, DA);
        chk("t1_log_len", log_q.size(), base + 1);

        // 2: read miss goes downstream ahead of the pending drain
        base = log_q.size();
        do_req("t2_wr", 2, 16'h1000, DC, 2, rd);
        do_req("t2_rd", 1, 16'h2000, '0, 0, rd);
        chk("t2_rdata", rd, {8{16'h7A5A}});
        wait_drained("t2");
        chk_log("t2_first_read", base, 0, 16'h2000, '0);
        chk_log("t2_then_drain", base + 1, 1, 16'h1000, DC);

        // 3: fill to full, third write forces a drain of the oldest line
        base = log_q.size();
        do_req("t3_wr0", 2, 16'h1000, DD, 2, rd);
        do_req("t3_wr1", 2, 16'h2000, DE, 2, rd);
        chk("t3_full", full, 1);
        do_req("t3_wr2", 2, 16'h3000, DF, 0, rd);
        chk_log("t3_evict", base, 1, 16'h1000, DD);
        chk("t3_full_again", full, 1);
        wait_drained("t3");
        chk_log("t3_drain1", base + 1, 1, 16'h2000, DE);
        chk_log("t3_drain2", base + 2, 1, 16'h3000, DF);
        chk("t3_log_len", log_q.size(), base + 3);

        // 4: coalesce two writes to the same line
        base = log_q.size();
        do_req("t4_wr0", 2, 16'h1000, DA, 2, rd);
        do_req("t4_wr1", 2, 16'h1008, DB, 2, rd);
        chk("t4_not_full", full, 0);
        wait_drained("t4");
        chk_log("t4_drain", base, 1, 16'h1000, DB);
        chk("t4_single_write", log_q.size(), base + 1);

        // 5: read of the line being drained misses after the pop
        base = log_q.size();
        do_req("t5_wr", 2, 16'h1000, DA, 2, rd);
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (mem_write) got = 1;
        end
        chk("t5_drain_started", got, 1);
        @(posedge clk);
        #1;
        chk("t5_rd_during_drain", mem_write, 1);
        do_req("t5_rd", 1, 16'h1000, '0, 0, rd);
        chk("t5_rdata", rd, {8{16'h4A5A}});
        wait_drained("t5");
        chk_log("t5_drain", base, 1, 16'h1000, DA);
        chk_log("t5_miss", base + 1, 0, 16'h1000, '0);

        // 6: reset in RD_MEM abandons the read; the late response is ignored
        auto_resp = 1'b0;
        do_req("t6_wr", 2, 16'h5000, DA, 2, rd);
        cur_addr   = 16'h4000;
        txn_id++;
        cur_op     = 1;
        dc_address = 16'h4000;
        dc_read    = 1'b1;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (mem_read) got = 1;
        end
        chk("t6_mem_read", got, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_mem_read", mem_read, 0);
        chk("t6_rst_empty", empty, 1);
        dc_read = 1'b0;
        cur_op  = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 fire_req++;
        got = 0;
        repeat (6) begin
            @(negedge clk);
            if (dc_resp) got = 1;
        end
        chk("t6_no_late_resp", got, 0);
        chk("t6_still_empty", empty, 1);
        auto_resp = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
